// File: rtl/mlp_pkg.sv
// Shared constants, state encoding and compare helper for the MLP inference sequencer.
package mlp_pkg;
  localparam int N_INPUT        = 432;
  localparam int N_OUTPUT       = 10;
  localparam int DATA_W         = 16;
  localparam int ADDR_W         = 12;
  localparam int TIMEOUT_CYCLES = 20000;

  localparam logic [1:0]        LAYER0_BASE    = 2'b00;
  localparam logic [1:0]        LAYER_OUT_BASE = 2'b11;
  localparam logic [DATA_W-1:0] SCORE_MIN      = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_ARGMAX = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

  function automatic logic signed_gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return $signed(a) > $signed(b);
  endfunction
endpackage

// File: rtl/mlp_argmax_unit.sv
// Streaming signed max tracker; o_best_* already includes the sample presented this cycle,
// so the final winner is available in the same cycle as the last compare.
module mlp_argmax_unit
  import mlp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_valid,
  input  logic [3:0]        i_idx,
  input  logic [DATA_W-1:0] i_data,
  output logic [3:0]        o_best_idx,
  output logic [DATA_W-1:0] o_best_score
);
  logic [3:0]        r_best_idx;
  logic [DATA_W-1:0] r_best_score;
  logic              w_take;

  // Strictly greater keeps the lowest index on ties.
  assign w_take       = i_valid && signed_gt(i_data, r_best_score);
  assign o_best_idx   = w_take ? i_idx  : r_best_idx;
  assign o_best_score = w_take ? i_data : r_best_score;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_best_idx   <= 4'd0;
      r_best_score <= SCORE_MIN;
    end else begin
      r_best_idx   <= o_best_idx;
      r_best_score <= o_best_score;
    end
  end
endmodule

// File: rtl/mlp_inference_sequencer.sv
// Sequences one MLP inference: pixel load, MAC run, output-layer argmax, result handshake.
// Optional RUN watchdog enabled by defining MLP_SEQ_TIMEOUT_EN.
module mlp_inference_sequencer
  import mlp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pixel_valid,
  output logic              pixel_ready,
  input  logic [DATA_W-1:0] pixel_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cu_reset,
  input  logic              cu_done,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [3:0]        result_class,
  output logic [DATA_W-1:0] result_score,
  output logic              busy,
  output logic              error
);
  state_t            r_state;
  logic [8:0]        r_pix_cnt;
  logic [4:0]        r_rd_idx;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_waddr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_re;
  logic [ADDR_W-1:0] r_mem_raddr;
  logic              r_cmp_valid;
  logic [3:0]        r_cmp_idx;
  logic              r_cu_reset;
  logic              r_result_valid;
  logic [3:0]        r_result_class;
  logic [DATA_W-1:0] r_result_score;
  logic              w_xfer;
  logic              w_clr;
  logic [4:0]        w_rd_next;
  logic [3:0]        w_best_idx;
  logic [DATA_W-1:0] w_best_score;
`ifdef MLP_SEQ_TIMEOUT_EN
  logic [14:0]       r_wd_cnt;
  logic              r_error;
  assign error = r_error;
`else
  assign error = 1'b0;
`endif

  assign pixel_ready  = (r_state == ST_LOAD);
  assign busy         = (r_state != ST_IDLE);
  assign w_xfer       = pixel_valid && pixel_ready;
  assign w_clr        = (r_state == ST_RUN) && cu_done;
  assign w_rd_next    = r_rd_idx + 5'd1;
  assign mem_we       = r_mem_we;
  assign mem_waddr    = r_mem_waddr;
  assign mem_wdata    = r_mem_wdata;
  assign mem_re       = r_mem_re;
  assign mem_raddr    = r_mem_raddr;
  assign cu_reset     = r_cu_reset;
  assign result_valid = r_result_valid;
  assign result_class = r_result_class;
  assign result_score = r_result_score;

  // Read data returns one cycle after mem_re, so the compare follows the read pipeline.
  mlp_argmax_unit u_argmax (
    .clk          (clk),
    .reset        (reset),
    .i_clr        (w_clr),
    .i_valid      (r_cmp_valid),
    .i_idx        (r_cmp_idx),
    .i_data       (mem_rdata),
    .o_best_idx   (w_best_idx),
    .o_best_score (w_best_score)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_pix_cnt      <= 9'd0;
      r_rd_idx       <= 5'd0;
      r_mem_we       <= 1'b0;
      r_mem_waddr    <= '0;
      r_mem_wdata    <= '0;
      r_mem_re       <= 1'b0;
      r_mem_raddr    <= '0;
      r_cmp_valid    <= 1'b0;
      r_cmp_idx      <= 4'd0;
      r_cu_reset     <= 1'b1;
      r_result_valid <= 1'b0;
      r_result_class <= 4'd0;
      r_result_score <= '0;
`ifdef MLP_SEQ_TIMEOUT_EN
      r_wd_cnt       <= 15'd0;
      r_error        <= 1'b0;
`endif
    end else begin
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_cmp_valid <= r_mem_re;
      r_cmp_idx   <= r_mem_raddr[3:0];
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_LOAD;
            r_pix_cnt <= 9'd0;
`ifdef MLP_SEQ_TIMEOUT_EN
            r_wd_cnt  <= 15'd0;
            r_error   <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          if (w_xfer) begin
            r_mem_we    <= 1'b1;
            r_mem_waddr <= {LAYER0_BASE, 1'b0, r_pix_cnt};
            r_mem_wdata <= pixel_data;
            r_pix_cnt   <= r_pix_cnt + 9'd1;
            if (r_pix_cnt == 9'(N_INPUT - 1)) begin
              r_state    <= ST_RUN;
              r_cu_reset <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (cu_done) begin
            r_state     <= ST_ARGMAX;
            r_rd_idx    <= 5'd0;
            r_mem_re    <= 1'b1;
            r_mem_raddr <= {LAYER_OUT_BASE, 5'b0, 5'd0};
          end
`ifdef MLP_SEQ_TIMEOUT_EN
          else if (r_wd_cnt == 15'(TIMEOUT_CYCLES - 1)) begin
            r_state        <= ST_RESULT;
            r_cu_reset     <= 1'b1;
            r_result_valid <= 1'b1;
            r_result_class <= 4'd0;
            r_result_score <= '0;
            r_error        <= 1'b1;
          end else begin
            r_wd_cnt <= r_wd_cnt + 15'd1;
          end
`endif
        end
        ST_ARGMAX: begin
          r_rd_idx <= w_rd_next;
          if (w_rd_next < 5'(N_OUTPUT)) begin
            r_mem_re    <= 1'b1;
            r_mem_raddr <= {LAYER_OUT_BASE, 5'b0, w_rd_next};
          end
          // Cycle N_OUTPUT carries the final compare; its result is taken directly.
          if (r_rd_idx == 5'(N_OUTPUT)) begin
            r_state        <= ST_RESULT;
            r_cu_reset     <= 1'b1;
            r_result_valid <= 1'b1;
            r_result_class <= w_best_idx;
            r_result_score <= w_best_score;
          end
        end
        ST_RESULT: begin
          if (result_ready) begin
            r_state        <= ST_IDLE;
            r_result_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/mlp_inference_sequencer.md
Name: mlp_inference_sequencer

Overview:
Top-level sequencer for one MLP inference. It streams 432 input pixels into neuron memory layer 0 over a valid/ready handshake, then releases the MAC control unit and waits for its done flag. It then reads the 10 output-layer neurons, computes a signed argmax, and presents the class on a valid/ready result port. It sits between the host/image loader and the neuron memory plus the control unit, and owns the memory write port and the control unit's reset.

Parameters:
N_INPUT, 432, input-layer neuron count (pixels per image)
N_OUTPUT, 10, output-layer neuron count (classes)
DATA_W, 16, neuron data width, two's complement
ADDR_W, 12, neuron memory address width
TIMEOUT_CYCLES, 20000, RUN watchdog limit (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  begin inference; sampled only in IDLE
pixel_valid  in  1  pixel stream valid
pixel_ready  out  1  pixel stream ready
pixel_data  in  DATA_W  pixel value
mem_we  out  1  neuron memory write enable
mem_waddr  out  ADDR_W  write address
mem_wdata  out  DATA_W  write data
mem_re  out  1  neuron memory read enable (argmax only)
mem_raddr  out  ADDR_W  read address
mem_rdata  in  DATA_W  read data, valid 1 cycle after mem_re
cu_reset  out  1  synchronous reset to MAC control unit
cu_done  in  1  MAC control unit done flag
result_valid  out  1  result available
result_ready  in  1  result consumed
result_class  out  4  argmax index 0..N_OUTPUT-1
result_score  out  DATA_W  winning neuron value
busy  out  1  state != IDLE
error  out  1  timeout flag (tied 0 without optional feature)

Behaviour:
- Reset (any time, including mid-operation): state IDLE; counters 0; pixel_ready=0, mem_we=0, mem_re=0, addresses/data 0, cu_reset=1, result_valid=0, result_class=0, result_score=0, busy=0, error=0.
- States: IDLE, LOAD, RUN, ARGMAX, RESULT.
- IDLE: cu_reset=1. start=1 -> LOAD with pix_cnt=0. start in any other state is ignored.
- LOAD: pixel_ready=1 combinationally. A transfer occurs on pixel_valid&&pixel_ready.
  - Each transfer registers a write: next cycle mem_we=1, mem_waddr={2'b00,1'b0,pix_cnt[8:0]}, mem_wdata=pixel_data.
  - pix_cnt increments per transfer. The transfer with pix_cnt==N_INPUT-1 moves the state to RUN; pixel_ready is 0 from that edge on.
  - Stalls (pixel_valid=0) are unbounded.
- RUN: cu_reset is registered and falls on the edge entering RUN. The last pixel's write pulse occurs in that same first RUN cycle. Stay until cu_done=1, then ARGMAX with rd_idx=0 and best score = most-negative value.
- ARGMAX:
  - For rd_idx 0..N_OUTPUT-1, one read per cycle: mem_re=1, mem_raddr={2'b11,5'b0,rd_idx[4:0]}.
  - Data for index k compares in the following cycle. Signed strictly-greater comparison updates best; ties keep the lowest index.
  - Total N_OUTPUT+1 cycles. After the last compare -> RESULT, and cu_reset reasserts.
- RESULT: result_valid=1. result_class and result_score hold stable until result_valid&&result_ready, then -> IDLE next edge with result_valid=0.
- mem_we and mem_re are never asserted in the same cycle. Outside LOAD/ARGMAX, both are 0.

Optional Feature:
MLP_SEQ_TIMEOUT_EN:
- Defined: a watchdog counts cycles in RUN. Reaching TIMEOUT_CYCLES without cu_done goes straight to RESULT with error=1, result_class=0, result_score=0. error clears on the next start.
- Undefined: no counter; RUN waits indefinitely; error is tied 0.

Decomposition:
- Shared package mlp_pkg: N_INPUT, N_OUTPUT, DATA_W, ADDR_W, layer-base constants (layer 0 = 2'b00, output layer = 2'b11), and the state enum encoding.
- One natural sub-module: mlp_argmax_unit, a streaming signed max tracker with clear, valid-in, index-in, and best index/score out.

Test Plan:
- Load pixels 0..431 with continuous valid, CU model asserts done after 100 cycles, output neurons {5,-3,9,2,9,0,0,0,1,-7} -> result_class=2, result_score=9, tie resolved to lowest index.
- Random pixel_valid gaps during LOAD -> exactly 432 writes, addresses 0x000..0x1AF in order, data matches stream, no write outside LOAD.
- All output neurons negative {-100,...,-5 at idx 7,...} -> class 7, score -5; no mem_re outside the 10 argmax cycles.
- result_ready held low 50 cycles -> result_valid and result fields stable; start pulses ignored; one ready pulse returns to IDLE.
- Reset asserted mid-LOAD (pixel 200) and mid-ARGMAX -> next cycle all outputs at reset values, cu_reset=1; a subsequent full inference is correct.
- With MLP_SEQ_TIMEOUT_EN and cu_done never asserted -> RESULT after exactly 20000 RUN cycles with error=1, class 0.
